cla_pipelined_adder: RTL
========================

// Module: cla_pipelined_adder
// PURPOSE
//  Parametrised, pipelined, elastic carry-lookahead adder. It is the registered
//  successor to the group-PG CLA network.
//  Computes A+B+CIN using two-level lookahead: bit PG, group PG, then group carries.
//  Supports a selectable number of pipeline stages behind a valid/ready handshake.
//  Sits between operand producers and datapath consumers wherever a wide adder
//  must close timing at speed.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of GROUP
//  GROUP   4   bits per lookahead group (the valency of the group black cell)
//  STAGES  2   pipeline register stages, legal values 1..3; equals latency in cycles
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operands present
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: carry into MSB XOR cout
// BEHAVIOUR
//  - Reset (async, while rst=1): all stage valid bits clear and all data registers
//    clear. Resulting values: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
//  - Handshake:
//    - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//    - Each stage k holds valid bit v[k]; stage STAGES drives the outputs.
//    - Stage k advances when ~v[k] | advance[k+1]; the last stage advances when
//      ~out_valid | out_ready. in_ready = advance of stage 1.
//    - No bubbles: throughput is 1 result/cycle while out_ready=1.
//    - A stalled stage holds its data and valid bit unchanged.
//    - in_ready depends combinationally on out_ready only; in_valid never drives
//      in_ready.
//    - Data presented while in_ready=0 is ignored; the producer must hold it.
//  - Stage partition:
//    - STAGES=1: whole add is combinational; one output register.
//    - STAGES=2: stage1 registers bit G=a&b, P=a^b, cin and group G/P
//      (WIDTH/GROUP groups). Stage2 computes the group carry chain, in-group
//      carries, sum, cout and ovf.
//    - STAGES=3: stage1 is as for STAGES=2. Stage2 registers the group carries
//      Gi[k*GROUP]. Stage3 computes in-group carries and sum.
//  - Latency: a result appears on outputs exactly STAGES cycles after acceptance,
//    plus any cycles the output stalls.
//  - Arithmetic:
//    - Unsigned wrap modulo 2^WIDTH; cout is the true bit WIDTH of the sum.
//    - ovf = c[WIDTH-1] ^ cout, valid for two's-complement operands.
//  - Boundaries:
//    - Carry ripples across all groups: a=all-ones, b=0, cin=1 gives sum=0, cout=1.
//    - Simultaneous accept and drain while full keeps occupancy constant.
//    - out_ready=0 with a full pipe gives in_ready=0, with no loss or duplication.
//    - rst asserted mid-operation drops all in-flight results immediately;
//      out_valid=0 in the same cycle.
//    - Elaboration fails ($error) if WIDTH%GROUP!=0 or STAGES outside 1..3.
// TESTING
//  - Reset mid-stream: assert rst with 2 results in flight -> out_valid=0 at once;
//    no stale result after release.
//  - Ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0, after
//    STAGES cycles.
//  - Overflow: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
//    a=16'h8000, b=16'h8000 -> sum=0, cout=1, ovf=1.
//  - Backpressure: stream 8 ops, hold out_ready=0 for 5 cycles -> in_ready falls
//    once STAGES entries are held; all 8 results arrive in order with no gaps
//    after release.
//  - Throughput: 1000 random ops with out_ready=1 and in_valid=1 -> 1 result per
//    cycle; every sum/cout matches the reference model a+b+cin.
//  - Parameter sweep: (WIDTH,GROUP,STAGES) = (8,2,1), (16,4,2), (32,8,3), (64,4,3)
//    under random in_valid/out_ready -> scoreboard shows zero mismatches.

Source files
------------

// File: rtl/cla_pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// master = producer/consumer side, slave = adder side.
interface cla_pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Elastic two-level carry-lookahead adder: bit PG -> group PG -> group carries -> sum.
// Latency is STAGES cycles; a stage stalls only while it and every stage after it are full.
module cla_pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic                  clk,
    input logic                  rst,
    cla_pipelined_adder_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    if (WIDTH % GROUP != 0) begin : g_bad_group
        $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("cla_pipelined_adder: STAGES must be 1, 2 or 3");
    end

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             cin;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
    } pg_t;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NG:0]      gc;   // gc[k] = carry into group k, gc[NG] = cout
    } gc_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    function automatic pg_t compute_pg(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             cin);
        pg_t  r;
        logic gg;
        logic gp;
        r.g   = a & b;
        r.p   = a ^ b;
        r.cin = cin;
        r.gg  = '0;
        r.gp  = '0;
        for (int k = 0; k < NG; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg = r.g[k*GROUP+i] | (r.p[k*GROUP+i] & gg);
                gp = gp & r.p[k*GROUP+i];
            end
            r.gg[k] = gg;
            r.gp[k] = gp;
        end
        return r;
    endfunction

    function automatic gc_t compute_gc(input pg_t s);
        gc_t r;
        r.g     = s.g;
        r.p     = s.p;
        r.gc    = '0;
        r.gc[0] = s.cin;
        for (int k = 0; k < NG; k++) begin
            r.gc[k+1] = s.gg[k] | (s.gp[k] & r.gc[k]);
        end
        return r;
    endfunction

    function automatic res_t compute_res(input gc_t s);
        res_t             r;
        logic [WIDTH-1:0] c;
        logic             cr;
        c = '0;
        for (int k = 0; k < NG; k++) begin
            cr = s.gc[k];
            for (int i = 0; i < GROUP; i++) begin
                c[k*GROUP+i] = cr;
                cr = s.g[k*GROUP+i] | (s.p[k*GROUP+i] & cr);
            end
        end
        r.sum  = s.p ^ c;
        r.cout = s.gc[NG];
        r.ovf  = c[WIDTH-1] ^ s.gc[NG];
        return r;
    endfunction

    logic [STAGES:1]   vld;
    logic [STAGES:1]   adv;
    logic [STAGES:1]   ld;
    logic [STAGES-1:0] vin;
    res_t              res_q;

    // A stage may advance unless it and all downstream stages are full and the consumer stalls.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int k = STAGES; k >= 1; k--) begin
            all_full = all_full & vld[k];
            adv[k]   = bus.out_ready | ~all_full;
        end
    end

    assign vin = STAGES'({vld, bus.in_valid});
    assign ld  = adv & vin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) vld[k] <= vin[k-1];
            end
        end
    end

    if (STAGES == 1) begin : g_s1
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        res_q <= '0;
            else if (ld[1]) res_q <= compute_res(compute_gc(compute_pg(bus.a, bus.b, bus.cin)));
        end
    end else begin : g_multi
        pg_t pg_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)        pg_q <= '0;
            else if (ld[1]) pg_q <= compute_pg(bus.a, bus.b, bus.cin);
        end

        if (STAGES == 2) begin : g_s2
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        res_q <= '0;
                else if (ld[2]) res_q <= compute_res(compute_gc(pg_q));
            end
        end else begin : g_s3
            gc_t gc_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gc_q  <= '0;
                    res_q <= '0;
                end else begin
                    if (ld[2]) gc_q  <= compute_gc(pg_q);
                    if (ld[3]) res_q <= compute_res(gc_q);
                end
            end
        end
    end

    assign bus.in_ready  = adv[1];
    assign bus.out_valid = vld[STAGES];
    assign bus.sum       = res_q.sum;
    assign bus.cout      = res_q.cout;
    assign bus.ovf       = res_q.ovf;
endmodule
